// File: rtl/key_event_pkg.sv
// key_event_pkg: code width and event entry layout shared by the key event unit.
package key_event_pkg;
  localparam int CODE_LSB = 0;
  function automatic int cw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int rpt_bit(input int n);
    return cw_of(n);
  endfunction
  function automatic int ew_of(input int n);
    return cw_of(n) + 1;
  endfunction
endpackage

// File: rtl/key_event_unit_debounce.sv
// key_debounce: 2-flop synchroniser and stability counter for one raw key line.
module key_debounce #(
  parameter int DB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic state
);
  localparam int CNTW = $clog2(DB_CYCLES);
  logic [1:0] sync;
  logic [CNTW-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      state <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] != state) begin
        if (cnt == CNTW'(DB_CYCLES - 1)) begin
          state <= ~state;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/key_event_unit.sv
// key_event_unit: debounced keys, press arbitration and event FIFO; KEY_EVENT_REPEAT_EN adds typematic repeat.
module key_event_unit
  import key_event_pkg::*;
#(
  parameter int N_KEYS     = 12,
  parameter int DB_CYCLES  = 1000,
  parameter int FIFO_DEPTH = 4,
  parameter int RPT_DELAY  = 5000000,
  parameter int RPT_PERIOD = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_KEYS-1:0]         keystroke,
  output logic [N_KEYS-1:0]         key_state,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [cw_of(N_KEYS)-1:0]  evt_code,
  output logic                      evt_repeat,
  output logic                      overflow
);
  localparam int CW = cw_of(N_KEYS);
  localparam int EW = ew_of(N_KEYS);
  localparam int RB = rpt_bit(N_KEYS);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [N_KEYS-1:0] ks_d, rise, pend, sel, clr;
  logic [CW-1:0] sel_code, rep_key;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head, entry;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic rpt_pend, rpt_sel, push, pop, full, any_pend;
  for (genvar k = 0; k < N_KEYS; k++) begin : g_db
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk(clk), .rst(rst), .raw(keystroke[k]), .state(key_state[k])
    );
  end
  assign rise = key_state & ~ks_d;
  assign sel = pend & (~pend + 1'b1);
  always_comb begin
    sel_code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) sel_code = pend[i] ? CW'(i) : sel_code;
  end
  assign any_pend  = |pend;
  assign full      = cnt[AW];
  assign evt_valid = cnt != '0;
  assign pop       = evt_valid & evt_ready;
  assign push      = (any_pend | rpt_pend) & (~full | pop);
  assign rpt_sel   = rpt_pend & ~any_pend;
  assign clr       = push ? sel : '0;
  always_comb begin
    entry = '0;
    entry[RB] = rpt_sel;
    entry[CODE_LSB +: CW] = any_pend ? sel_code : rep_key;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_d     <= '0;
      pend     <= '0;
      overflow <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
    end else begin
      ks_d     <= key_state;
      pend     <= (pend & ~clr) | rise;
      overflow <= overflow | (|(rise & pend & ~clr));
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= entry;
  assign head       = mem[rp];
  assign evt_code   = evt_valid ? head[CODE_LSB +: CW] : '0;
  assign evt_repeat = evt_valid & head[RB];
`ifdef KEY_EVENT_REPEAT_EN
  localparam int TW = $clog2((RPT_DELAY > RPT_PERIOD ? RPT_DELAY : RPT_PERIOD) + 1);
  logic [TW-1:0] tmr;
  logic [CW-1:0] rk_next;
  logic expire;
  always_comb begin
    rk_next = rep_key;
    for (int i = 0; i < N_KEYS; i++) rk_next = rise[i] ? CW'(i) : rk_next;
  end
  assign expire = key_state[rep_key] && tmr == TW'(1) && !(|rise);
  // Press detection and the push each take a cycle, so the first load is
  // shortened by two to place the repeat event RPT_DELAY after key_state rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_key  <= '0;
      tmr      <= '0;
      rpt_pend <= 1'b0;
    end else begin
      rpt_pend <= (rpt_pend & ~(push & rpt_sel)) | expire;
      if (|rise) begin
        rep_key <= rk_next;
        tmr     <= TW'(RPT_DELAY - 2);
      end else if (!key_state[rep_key]) tmr <= '0;
      else if (expire) tmr <= TW'(RPT_PERIOD);
      else if (tmr != '0) tmr <= tmr - 1'b1;
    end
  end
`else
  assign rpt_pend = 1'b0;
  assign rep_key  = '0;
`endif
endmodule

// File: tb/tb_key_event_unit.sv
// tb_key_event_unit: directed vector table plus hand sequences for key_event_unit.
module tb_key_event_unit;
  localparam int NK = 12;
`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, evt_ready = 1'b1;
  logic [NK-1:0] keystroke = '0, key_state;
  logic evt_valid, evt_repeat, overflow;
  logic [3:0] evt_code;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  key_event_unit #(
    .N_KEYS(NK), .DB_CYCLES(4), .FIFO_DEPTH(4), .RPT_DELAY(20), .RPT_PERIOD(8)
  ) dut (
    .clk(clk), .rst(rst), .keystroke(keystroke), .key_state(key_state),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_repeat(evt_repeat), .overflow(overflow)
  );
  typedef struct {
    logic [NK-1:0] keys;
    logic rdy;
    int n;
    logic [NK-1:0] ks;
    logic v;
    logic [3:0] code;
    logic rp;
    logic ov;
  } vec_t;
  vec_t tbl [16];
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic [NK-1:0] ks, input logic v,
                         input logic [3:0] c, input logic r, input logic o);
    chk({nm, ".key_state"}, 32'(key_state), 32'(ks));
    chk({nm, ".evt_valid"}, 32'(evt_valid), 32'(v));
    chk({nm, ".evt_code"}, 32'(evt_code), 32'(c));
    chk({nm, ".evt_repeat"}, 32'(evt_repeat), 32'(r));
    chk({nm, ".overflow"}, 32'(overflow), 32'(o));
  endtask
  task automatic press(input int i);
    keystroke = NK'(1) << i;
    tick(7);
    keystroke = '0;
    tick(8);
  endtask
  initial begin
    tbl[0]  = '{12'h002, 1'b1, 3, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{12'h000, 1'b1, 1, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{12'h000, 1'b1, 3, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[3]  = '{12'h000, 1'b1, 4, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[4]  = '{12'h080, 1'b1, 5, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{12'h080, 1'b1, 1, 12'h080, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[6]  = '{12'h080, 1'b1, 1, 12'h080, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{12'h080, 1'b1, 1, 12'h080, 1'b1, 4'd7, 1'b0, 1'b0};
    tbl[8]  = '{12'h080, 1'b1, 1, 12'h080, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[9]  = '{12'h000, 1'b1, 8, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[10] = '{12'h082, 1'b0, 7, 12'h082, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[11] = '{12'h082, 1'b0, 1, 12'h082, 1'b1, 4'd1, 1'b0, 1'b0};
    tbl[12] = '{12'h082, 1'b0, 1, 12'h082, 1'b1, 4'd1, 1'b0, 1'b0};
    tbl[13] = '{12'h082, 1'b1, 1, 12'h082, 1'b1, 4'd7, 1'b0, 1'b0};
    tbl[14] = '{12'h082, 1'b1, 1, 12'h082, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[15] = '{12'h000, 1'b1, 8, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0};
    #1;
    chk_all("reset", '0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      keystroke = tbl[i].keys;
      evt_ready = tbl[i].rdy;
      tick(tbl[i].n);
      chk_all($sformatf("row%0d", i), tbl[i].ks, tbl[i].v, tbl[i].code, tbl[i].rp, tbl[i].ov);
    end
    // hold key 3: press event at t=2, repeats only in the repeat build
    evt_ready = 1'b1;
    keystroke = 12'h008;
    tick(6);
    chk("rpt.ks_rise", 32'(key_state), 32'h008);
    for (int t = 1; t <= 60; t++) begin
      logic ev, er;
      tick(1);
      er = REP && (t == 20 || t == 28 || t == 36);
      ev = (t == 2) || er;
      chk($sformatf("rpt.t%0d.valid", t), 32'(evt_valid), 32'(ev));
      chk($sformatf("rpt.t%0d.code", t), 32'(evt_code), ev ? 32'd3 : 32'd0);
      chk($sformatf("rpt.t%0d.repeat", t), 32'(evt_repeat), 32'(er));
      if (t == 31) keystroke = '0;
    end
    chk("rpt.ks_fall", 32'(key_state), 32'h000);
    // fill the FIFO, leave key 4 pending, then press it again
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) press(i);
    chk_all("full", '0, 1'b1, 4'd0, 1'b0, 1'b0);
    press(4);
    chk_all("ovf", '0, 1'b1, 4'd0, 1'b0, 1'b1);
    evt_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk_all($sformatf("drain%0d", i), '0, 1'b1, 4'(i), 1'b0, 1'b1);
    end
    tick(1);
    chk_all("drain_empty", '0, 1'b0, 4'd0, 1'b0, 1'b1);
    // reset with three entries queued and key 5 held
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) press(i);
    keystroke = 12'h020;
    tick(6);
    chk_all("pre_rst", 12'h020, 1'b1, 4'd0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk_all("mid_rst", '0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    rst = 1'b0;
    evt_ready = 1'b1;
    tick(6);
    chk_all("post_rst_ks", 12'h020, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    chk_all("post_rst_wait", 12'h020, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    chk_all("post_rst_evt", 12'h020, 1'b1, 4'd5, 1'b0, 1'b0);
    tick(1);
    chk_all("post_rst_pop", 12'h020, 1'b0, 4'd0, 1'b0, 1'b0);
    keystroke = '0;
    tick(8);
    chk_all("final", '0, 1'b0, 4'd0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
